// File: rtl/antares_div_ctrl.sv
// antares_div_ctrl: sequencer between the EX stage and the multi-cycle divider.
// It accepts one divide request and sends a one-cycle start pulse to the divider.
// It waits for the divider to finish, then writes the quotient to LO and the remainder to HI.
// It also handles MTHI/MTLO writes, pipeline flush and the divisor == 0 flag.
// Optional feature: define ANTARES_DIV0_FAST_EN to finish a divide by zero in one cycle.
// That path skips the divider and writes HI = dividend, LO = ZERO_QUOT.
module antares_div_ctrl #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] ZERO_QUOT = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_dividend,
  input  logic [DATA_W-1:0] req_divisor,
  output logic              req_ready,
  input  logic              flush,
  input  logic              hilo_we,
  input  logic              hilo_sel,
  input  logic [DATA_W-1:0] hilo_wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic              div_op_divs,
  output logic              div_op_divu,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic [DATA_W-1:0] div_quotient,
  input  logic [DATA_W-1:0] div_remainder,
  input  logic              div_stall
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ZERO  = 2'd3
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [DATA_W-1:0] dividend_reg;
  logic [DATA_W-1:0] divisor_reg;
  logic              signed_reg;
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] lo_reg;
  logic              done_reg;
  logic              div_zero_reg;
  logic              accept;

  assign accept = req_valid & req_ready;

  // State register; reset abandons any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; flush always returns to IDLE from an active state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
`ifdef ANTARES_DIV0_FAST_EN
          if (req_divisor == '0) state_next = S_ZERO;
          else                   state_next = S_ISSUE;
`else
          state_next = S_ISSUE;
`endif
        end
      end
      S_ISSUE: state_next = flush ? S_IDLE : S_WAIT;
      S_WAIT:  if (flush || !div_stall) state_next = S_IDLE;
`ifdef ANTARES_DIV0_FAST_EN
      S_ZERO:  state_next = S_IDLE;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the start pulse lasts exactly the ISSUE cycle
  always_comb begin
    req_ready   = (state_reg == S_IDLE) & ~flush;
    busy        = (state_reg != S_IDLE);
    div_op_divs = (state_reg == S_ISSUE) &  signed_reg;
    div_op_divu = (state_reg == S_ISSUE) & ~signed_reg;
  end

  // Operand latch, HI/LO update and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_reg <= '0;
      divisor_reg  <= '0;
      signed_reg   <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // An MTHI/MTLO write in the same cycle as an acceptance still lands;
          // the divide result overwrites it later.
          if (hilo_we) begin
            if (hilo_sel) hi_reg <= hilo_wdata;
            else          lo_reg <= hilo_wdata;
          end
          if (accept) begin
            dividend_reg <= req_dividend;
            divisor_reg  <= req_divisor;
            signed_reg   <= req_signed;
            div_zero_reg <= (req_divisor == '0);
          end
        end
        S_WAIT: begin
          // flush takes priority over a capture in the same cycle
          if (!flush && !div_stall) begin
            lo_reg   <= div_quotient;
            hi_reg   <= div_remainder;
            done_reg <= 1'b1;
          end
        end
`ifdef ANTARES_DIV0_FAST_EN
        S_ZERO: begin
          if (!flush) begin
            lo_reg   <= ZERO_QUOT;
            hi_reg   <= dividend_reg;
            done_reg <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign hi           = hi_reg;
  assign lo           = lo_reg;
  assign done         = done_reg;
  assign div_zero     = div_zero_reg;
  assign div_dividend = dividend_reg;
  assign div_divisor  = divisor_reg;

endmodule
